// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data
// requesters. Round-robin grant, one transaction in flight, and a bounded wait
// on mem_ready that completes with err when the memory never answers.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

  state_t        state_q, state_d;
  src_t          last_q, last_d;
  src_t          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  src_t          sel;
  logic          any_req;

  // Round-robin pick: on contention, the requester that did not win last time.
  always_comb begin
    sel     = SRC_FETCH;
    any_req = if_req | d_req;
    if (if_req && d_req) begin
      sel = (last_q == SRC_DATA) ? SRC_FETCH : SRC_DATA;
    end else if (d_req) begin
      sel = SRC_DATA;
    end
  end

  // Next-state and next-output logic; acks and err are single-cycle by default.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          last_d  = sel;
          cnt_d   = '0;
          state_d = S_BUSY;
          if (sel == SRC_FETCH) begin
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end else begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_read_d  = ~d_we;
            mem_write_d = d_we;
          end
        end
      end

      S_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RESP;
          if (gnt_q == SRC_FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_write_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          state_d     = S_RESP;
          if (gnt_q == SRC_FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_q      <= SRC_DATA;
      gnt_q       <= SRC_FETCH;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // CPU stall while any request is still waiting for its acknowledge.
  assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps, memory responder model and
// expected-transaction / expected-response queues.
module tb_mem_port_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          err;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
  } mem_t;

  rsp_t exp_rsp[$];
  mem_t exp_mem[$];

  int checks = 0;
  int errors = 0;
  int lat = 0;
  bit hang = 1'b0;
  int busy = 0;
  int strobe_len = 0;
  logic [DW-1:0] cur_if = '0;
  logic [DW-1:0] cur_d = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [AW-1:0] a);
    mem_t m;
    rsp_t r;
    m.addr = a; m.we = 1'b0; m.wdata = '0;
    r.is_d = 1'b0; r.err = hang; r.rdata = hang ? '0 : model(a);
    cur_if = r.rdata;
    exp_mem.push_back(m);
    exp_rsp.push_back(r);
  endtask

  task automatic push_data(input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    mem_t m;
    rsp_t r;
    m.addr = a; m.we = we; m.wdata = wd;
    r.is_d = 1'b1; r.err = hang;
    r.rdata = hang ? '0 : (we ? cur_d : model(a));
    cur_d = r.rdata;
    exp_mem.push_back(m);
    exp_rsp.push_back(r);
  endtask

  // Wait (bounded) for the wanted acks, scoring each response and the stall.
  task automatic wait_acks(input bit want_if, input bit want_d, output int if_cyc, output int d_cyc);
    int cyc;
    bit got_if;
    bit got_d;
    bit exp_stall;
    rsp_t r;
    cyc = 0;
    got_if = !want_if;
    got_d = !want_d;
    if_cyc = -1;
    d_cyc = -1;
    while (!(got_if && got_d) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_ack || d_ack) begin
        check("one_ack", 32'(if_ack && d_ack), 32'd0);
        check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("ack_port", 32'(d_ack), 32'(r.is_d));
          check("ack_rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
          check("ack_err", 32'(err), 32'(r.err));
        end
        exp_stall = if_ack ? (want_d && !got_d) : (want_if && !got_if);
        check("stall_ack_cycle", 32'(stall), 32'(exp_stall));
        if (if_ack) begin got_if = 1'b1; if_cyc = cyc; if_req = 1'b0; end
        if (d_ack) begin got_d = 1'b1; d_cyc = cyc; d_req = 1'b0; end
      end else begin
        check("stall_pending", 32'(stall), 32'd1);
      end
    end
    check("acks_received", {30'd0, got_if, got_d}, 32'd3);
  endtask

  // Memory model: checks each new strobe against the expected transaction and
  // raises mem_ready 'lat' cycles after the strobe appears (never when hang).
  initial begin
    mem_t m;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (busy == 0) begin
          check("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
          check("mem_txn_expected", 32'(exp_mem.size() != 0), 32'd1);
          if (exp_mem.size() != 0) begin
            m = exp_mem.pop_front();
            check("mem_addr", mem_addr, m.addr);
            check("mem_write", 32'(mem_write), 32'(m.we));
            if (m.we) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (!hang && busy == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_read ? model(mem_addr) : 32'hBAD0BAD0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'h0;
        end
        busy++;
      end else begin
        if (busy != 0) strobe_len = busy;
        busy = 0;
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ic;
    int dc;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // First contention after reset: fetch then data
    lat = 0;
    push_fetch(32'h200);
    push_data(32'h300, 1'b0, 32'h0);
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    wait_acks(1'b1, 1'b1, ic, dc);
    check("t2_if_cycle", 32'(ic), 32'd2);
    check("t2_d_cycle", 32'(dc), 32'd5);
    @(negedge clk);

    // Single fetch, ready with strobe
    push_fetch(32'h40);
    if_req = 1'b1; if_addr = 32'h40;
    wait_acks(1'b1, 1'b0, ic, dc);
    check("t1_if_cycle", 32'(ic), 32'd2);
    @(negedge clk);
    check("t1_strobe_len", 32'(strobe_len), 32'd1);
    check("t1_if_rdata_hold", if_rdata, 32'h8C010004);

    // Contention after a fetch grant: data goes first
    push_data(32'h480, 1'b0, 32'h0);
    push_fetch(32'h500);
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h480;
    wait_acks(1'b1, 1'b1, ic, dc);
    check("t2b_d_cycle", 32'(dc), 32'd2);
    check("t2b_if_cycle", 32'(ic), 32'd5);
    @(negedge clk);

    // Store, ready on third strobe cycle; d_rdata must not change
    lat = 2;
    push_data(32'h100, 1'b1, 32'hDEADBEEF);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    wait_acks(1'b0, 1'b1, ic, dc);
    check("t3_d_cycle", 32'(dc), 32'd4);
    @(negedge clk);
    check("t3_strobe_len", 32'(strobe_len), 32'd3);
    d_we = 1'b0;

    // Timeout: memory never ready
    hang = 1'b1;
    push_fetch(32'h600);
    if_req = 1'b1; if_addr = 32'h600;
    wait_acks(1'b1, 1'b0, ic, dc);
    check("t4_if_cycle", 32'(ic), 32'd17);
    @(negedge clk);
    check("t4_strobe_len", 32'(strobe_len), 32'd16);
    check("t4_err_cleared", 32'(err), 32'd0);

    // Reset while BUSY abandons the load; pending request is re-granted
    mem_t_push: begin
      mem_t m;
      m.addr = 32'h700; m.we = 1'b0; m.wdata = '0;
      exp_mem.push_back(m);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    repeat (3) @(negedge clk);
    check("t5_busy_strobe", 32'(mem_read), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_mem_read", 32'(mem_read), 32'd0);
    check("t5_rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("t5_rst_d_rdata", d_rdata, 32'd0);
    cur_d = '0;
    cur_if = '0;
    hang = 1'b0;
    lat = 1;
    push_data(32'h700, 1'b0, 32'h0);
    rst = 1'b1;
    wait_acks(1'b0, 1'b1, ic, dc);
    check("t5_regrant_cycle", 32'(dc), 32'd3);
    repeat (2) @(negedge clk);
    check("final_rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    check("final_mem_queue_empty", 32'(exp_mem.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
